// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns the memory stage's single-cycle load/store into one
//   split-transaction SRAM-like bus access (addr_ok / data_ok), stalls the
//   pipeline while it is outstanding and holds the last load word for writeback.
// Latency: best case one stall cycle (accept in cycle 0, data_ok in cycle 1,
//   rd valid from cycle 2). Backpressure: stall is raised while the request
//   waits for addr_ok, waits for data_ok, or drains a flushed transfer.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   ren, wen, addr, size,
//   wdata                 - memory-stage access request (held stable while stalled)
//   flush, stall_other    - kill of the memory-stage instruction / external stall
//   rd                    - registered load data for writeback
//   stall                 - pipeline freeze to the hazard unit
//   data_*                - SRAM-like data bus (request, accept, completion)
module data_sram_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic        flush,
  input  logic        stall_other,
  output logic [31:0] rd,
  output logic        stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rd_q, rd_d;
  // Remembers whether the transaction in flight is a load, so the capture
  // decision does not depend on the stage inputs at data_ok time.
  logic        load_q, load_d;
  logic        access;

  assign access = (ren | wen) & ~flush;

  // Address/data/size pass straight through: the stage is frozen while the
  // request is pending, so these are stable for the whole handshake.
  assign data_wr    = wen;
  assign data_size  = size;
  assign data_addr  = addr;
  assign data_wdata = wdata;
  assign rd         = rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rd_q    <= 32'h0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    load_d   = load_q;
    data_req = 1'b0;
    stall    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          data_req = 1'b1;
          stall    = 1'b1;
          load_d   = ren;
          state_d  = data_addr_ok ? S_WAIT : S_REQ;
        end
      end

      S_REQ: begin
        // Dropping an unaccepted request on flush is legal on this bus.
        data_req = 1'b1;
        stall    = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (data_addr_ok) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (data_data_ok) begin
          // Completing cycle releases the stall so the stage advances together
          // with the capture; rd is then valid when it reaches writeback.
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            if (load_q) begin
              rd_d = data_rdata;
            end
            state_d = stall_other ? S_DONE : S_IDLE;
          end
        end else begin
          stall = 1'b1;
          if (flush) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DONE: begin
        // Access already completed; the stage is still held by someone else
        // and still presents the same request, which must not be reissued.
        if (!stall_other || flush) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        // The bus still owes a data_ok for the killed access; absorb it.
        stall = 1'b1;
        if (data_data_ok) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
